// File: rtl/sp1_ff_pipe.sv
// Elastic register pipeline of DEPTH stages with collapsing bubbles.
// Optional occupancy counter port occ under SP1_FF_PIPE_CNT_EN.
module sp1_ff_pipe #(
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  input  logic          flush
`ifdef SP1_FF_PIPE_CNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

  logic [DEPTH-1:0] r_v;
  logic [DW-1:0]    r_d [DEPTH];
  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_ld;
  logic [DW-1:0]    w_src [DEPTH];
  logic             w_acc;

  // A stage may move on when the next one is empty or moving itself.
  assign w_adv[DEPTH-1] = out_ready;
  for (genvar i = 0; i < DEPTH-1; i++) begin : g_adv
    assign w_adv[i] = ~r_v[i+1] | w_adv[i+1];
  end

  assign in_ready = (~r_v[0] | w_adv[0]) & ~flush & ~rst;
  assign w_acc    = in_valid & in_ready;

  assign w_ld[0]  = w_acc;
  assign w_src[0] = in_data;
  for (genvar i = 1; i < DEPTH; i++) begin : g_ld
    assign w_ld[i]  = w_adv[i-1] & r_v[i-1] & ~flush;
    assign w_src[i] = r_d[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) r_d[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush)         r_v[i] <= 1'b0;
        else if (w_ld[i])  r_v[i] <= 1'b1;
        else if (w_adv[i]) r_v[i] <= 1'b0;
        if (w_ld[i]) r_d[i] <= w_src[i];
      end
    end
  end

  assign out_valid = r_v[DEPTH-1];
  assign out_data  = r_d[DEPTH-1];

`ifdef SP1_FF_PIPE_CNT_EN
  localparam int CW = $clog2(DEPTH+1);
  logic [CW-1:0] r_occ;
  logic          w_pop;

  assign w_pop = r_v[DEPTH-1] & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_occ <= '0;
    else if (flush)          r_occ <= '0;
    else if (w_acc & ~w_pop) r_occ <= r_occ + CW'(1);
    else if (w_pop & ~w_acc) r_occ <= r_occ - CW'(1);
  end

  assign occ = r_occ;
`endif

endmodule
